ntt_out_reorder: RTL
====================

Name: ntt_out_reorder

Overview:
- Sits directly downstream of the dual-lane pipelined NTT and consumes its out_en/out[2] stream.
- That stream arrives in bit-reversed order, two coefficients per cycle, with no back-pressure.
- The block captures each polynomial into a ping-pong buffer and replays it in natural order to the pointwise-multiply/store stage under a valid/ready handshake.
- It flags an overflow if the NTT produces a third polynomial while both buffers are still occupied.

Parameters:
- DATA_WIDTH, ntt_pkg::DATA_WIDTH, coefficient width.
- LOG_N, ntt_pkg::NTT_STAGE_CNT+1, log2 of coefficients per polynomial (default 8, so N=256, N/2=128 pairs).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_en  in  1  pair valid from the NTT last stage; cannot be stalled
- in  in  2xDATA_WIDTH  coefficient pair from the NTT
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts the pair
- out  out  2xDATA_WIDTH  out[0]=coef m, out[1]=coef m+N/2
- out_last  out  1  high with pair m=N/2-1
- overflow  out  1  sticky error flag

Behaviour:
- Reset values: out_valid=0, out_last=0, out=0, overflow=0; both buffers empty; write and read set pointers = 0; wcnt=0, rcnt=0.
- Input mapping: the k-th accepted pair (k=0..N/2-1) carries natural indices bitrev_{LOG_N-1}(k) on in[0] and N/2+bitrev_{LOG_N-1}(k) on in[1].
  - in[0] is written to the low bank of the current write set at address bitrev(k).
  - in[1] is written to the high bank at the same address.
  - Both writes happen in the same cycle; the banks never conflict.
- wcnt counts only on cycles where in_en=1. Gaps in in_en hold wcnt.
  - When wcnt wraps from N/2-1 to 0, the write set is marked full and the write pointer toggles.
- Overflow condition: in_en=1 while the write set is still full (not yet drained).
  - The pair is dropped and overflow is set until reset.
  - wcnt still advances, so the stream stays aligned to polynomial boundaries and subsequent pairs of that polynomial are also dropped.
- Read FSM states:
  - IDLE: go to FETCH when the read set is full.
  - FETCH: issue bank read at rcnt; 1-cycle RAM latency.
  - SHOW: out_valid=1 with registered data.
- In SHOW:
  - On out_ready=1, rcnt increments and the next address is prefetched, so back-to-back transfers run at 1 pair/cycle.
  - When out_ready=0, out, out_valid and out_last hold stable.
  - After the handshake with rcnt=N/2-1: out_last was 1 on that pair, the set is marked empty, the read pointer toggles, and the FSM goes to FETCH if the other set is full, else IDLE.
- Latency: the last write of a polynomial in cycle t gives out_valid=1 in cycle t+2, provided the read side was IDLE.
- Simultaneous events:
  - The set going full (write side) and the other set going empty (read side) in the same cycle are both honoured.
  - A write into a set in the same cycle it is freed is legal, because writes only target the non-read set.
- Reset mid-operation discards partial and stored polynomials; the next in_en pair is k=0.
- Arithmetic: none; data passes bit-exact.

Decomposition:
- ntt_pkg: add function bitrev(value, bits) and localparam N_HALF=1<<(LOG_N-1).
- Banks: four dp_ram-style instances (2 sets x 2 banks, WIDTH=DATA_WIDTH, DEPTH=N_HALF), each with separate write and read addresses.
- Sub-module: ntt_reorder_rd_fsm holds the read FSM, rcnt and the output register.

Test Plan:
- Single polynomial, in_en continuous for 128 cycles, in pair k = {bitrev7(k), 128+bitrev7(k)}, out_ready=1.
  -> out_valid rises 2 cycles after the last write.
  -> 128 consecutive pairs out={m, m+128}; out_last only at m=127.
- Same stimulus with out_ready toggled 1,0,0,1...
  -> out held stable while stalled; no pair lost or duplicated; overflow=0.
- Three polynomials back-to-back (384 in_en cycles), out_ready=1.
  -> all three replay in order, the second starting on the cycle after the first's out_last.
  -> overflow=0.
- out_ready=0 held during three back-to-back polynomials.
  -> overflow=1 at the first pair of the third polynomial.
  -> after out_ready=1, exactly polynomials 1 and 2 are output.
- in_en with random gaps (for example 1 cycle of 5 low).
  -> output identical to the continuous case.
- rst pulsed after 60 pairs of the first polynomial, then a full polynomial is sent.
  -> outputs 0 during and after reset; the next output is a clean polynomial starting at out={0, 128}.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT constants, read-side state encoding and the bit-reversal helper.
package ntt_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned NTT_STAGE_CNT = 7;
    localparam int unsigned LOG_N         = NTT_STAGE_CNT + 1;
    localparam int unsigned N_HALF        = 1 << (LOG_N - 1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_SHOW
    } rd_state_e;

    // Reverses the low 'bits' bits of value; upper result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned bits);
        logic [31:0] v;
        logic [31:0] r;
        v = value;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = {r[30:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: registered write port, asynchronous read port.
module dp_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ntt_reorder_rd_fsm.sv
// Read-side sequencer: walks the full set in natural order and presents
// registered coefficient pairs under a valid/ready handshake.
module ntt_reorder_rd_fsm #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AW         = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 full_i,
    input  logic [1:0][DATA_WIDTH-1:0] rd_data_i,
    output logic                       rd_set_o,
    output logic [AW-1:0]              rd_addr_o,
    output logic                       free_o,
    output logic                       free_set_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0] out_o,
    output logic                       out_last_o
);
    import ntt_pkg::*;

    localparam logic [AW-1:0] CNT_LAST = '1;
    localparam logic [AW-1:0] CNT_PREV = CNT_LAST - 1'b1;

    rd_state_e                 state_q;
    logic                      rset_q;
    logic [AW-1:0]             rcnt_q;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic [1:0][DATA_WIDTH-1:0] out_q;

    logic hs;
    logic done;
    logic chain;

    // Address is prefetched on the handshake so transfers sustain 1 pair/cycle,
    // including across a set boundary when the other set is already full.
    always_comb begin
        hs    = (state_q == RD_SHOW) && out_ready_i;
        done  = hs && (rcnt_q == CNT_LAST);
        chain = done && full_i[!rset_q];
        rd_set_o   = chain ? !rset_q : rset_q;
        free_o     = done;
        free_set_o = rset_q;
        if (done) begin
            rd_addr_o = '0;
        end else if (hs) begin
            rd_addr_o = rcnt_q + 1'b1;
        end else begin
            rd_addr_o = rcnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            rset_q      <= 1'b0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (full_i[rset_q]) begin
                        state_q <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    out_q       <= rd_data_i;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (rcnt_q == CNT_LAST);
                    state_q     <= RD_SHOW;
                end
                RD_SHOW: begin
                    if (out_ready_i) begin
                        if (rcnt_q == CNT_LAST) begin
                            rcnt_q     <= '0;
                            rset_q     <= !rset_q;
                            out_last_q <= 1'b0;
                            if (full_i[!rset_q]) begin
                                out_q <= rd_data_i;
                            end else begin
                                out_valid_q <= 1'b0;
                                state_q     <= RD_IDLE;
                            end
                        end else begin
                            rcnt_q     <= rcnt_q + 1'b1;
                            out_q      <= rd_data_i;
                            out_last_q <= (rcnt_q == CNT_PREV);
                        end
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_o       = out_q;

endmodule

// File: rtl/ntt_out_reorder.sv
// Captures bit-reversed NTT output pairs into a ping-pong buffer and replays
// each polynomial in natural order; flags overflow when both sets are occupied.
module ntt_out_reorder #(
    parameter int unsigned DATA_WIDTH = ntt_pkg::DATA_WIDTH,
    parameter int unsigned LOG_N      = ntt_pkg::NTT_STAGE_CNT + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_en,
    input  logic [1:0][DATA_WIDTH-1:0] in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0][DATA_WIDTH-1:0] out,
    output logic                       out_last,
    output logic                       overflow
);
    import ntt_pkg::*;

    localparam int unsigned   AW       = LOG_N - 1;
    localparam int unsigned   NH       = 1 << AW;
    localparam logic [AW-1:0] CNT_LAST = AW'(NH - 1);

    logic          wset_q, wset_d;
    logic [1:0]    full_q, full_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          drop_poly_q, drop_poly_d;
    logic          overflow_q, overflow_d;

    logic          wrap, drop, wr_en, fill;
    logic [AW-1:0] wr_addr;
    logic [1:0]    full_eff;

    logic          rd_set;
    logic [AW-1:0] rd_addr;
    logic          rd_free;
    logic          rd_free_set;

    logic [1:0][DATA_WIDTH-1:0] bank_rdata [2];

    // A polynomial that lost any pair is never marked full, so a set drained
    // mid-polynomial cannot be replayed with a torn mix of old and new data.
    always_comb begin
        wr_addr     = AW'(bitrev(32'(wcnt_q), AW));
        wrap        = in_en && (wcnt_q == CNT_LAST);
        drop        = in_en && full_q[wset_q] && !(rd_free && (rd_free_set == wset_q));
        wr_en       = in_en && !drop;
        fill        = wrap && !drop && !drop_poly_q;
        full_eff    = full_q;
        if (fill) begin
            full_eff[wset_q] = 1'b1;
        end
        full_d      = full_eff;
        if (rd_free && !(fill && (rd_free_set == wset_q))) begin
            full_d[rd_free_set] = 1'b0;
        end
        wcnt_d      = in_en ? wcnt_q + 1'b1 : wcnt_q;
        wset_d      = fill ? !wset_q : wset_q;
        drop_poly_d = wrap ? 1'b0 : (drop_poly_q || drop);
        overflow_d  = overflow_q || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wset_q      <= 1'b0;
            full_q      <= '0;
            wcnt_q      <= '0;
            drop_poly_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wset_q      <= wset_d;
            full_q      <= full_d;
            wcnt_q      <= wcnt_d;
            drop_poly_q <= drop_poly_d;
            overflow_q  <= overflow_d;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_set
        for (genvar b = 0; b < 2; b++) begin : g_bank
            dp_ram #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (NH)
            ) u_ram (
                .clk     (clk),
                .we_i    (wr_en && (wset_q == 1'(s))),
                .waddr_i (wr_addr),
                .wdata_i (in[b]),
                .raddr_i (rd_addr),
                .rdata_o (bank_rdata[s][b])
            );
        end
    end

    ntt_reorder_rd_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_rd_fsm (
        .clk         (clk),
        .rst         (rst),
        .full_i      (full_eff),
        .rd_data_i   (bank_rdata[rd_set]),
        .rd_set_o    (rd_set),
        .rd_addr_o   (rd_addr),
        .free_o      (rd_free),
        .free_set_o  (rd_free_set),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out),
        .out_last_o  (out_last)
    );

    assign overflow = overflow_q;

endmodule
